uart_debug_mon: RTL

//  Parametrised debug monitor for the UART core, on the 32-bit debug port.

---
 rtl/uart_debug_mon.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_debug_mon.sv
// Debug monitor for the UART core: live/snapshot status words, saturating frame
// counters and a timestamped trace FIFO of LSR changes, read over a 32-bit port.
module uart_debug_mon #(
    parameter int UART_ADDR_W = 5,
    parameter int FIFO_CNT_W  = 5,
    parameter int CNT_W       = 16,
    parameter int TRACE_AW    = 3,
    parameter int IRQ_THRESH  = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [UART_ADDR_W-1:0] wb_adr_i,
    input  logic                   wb_re_i,
    input  logic                   wb_we_i,
    input  logic [31:0]            wb_dat_i,
    output logic [31:0]            wb_dat32_o,
    input  logic [3:0]             ier,
    input  logic [3:0]             iir,
    input  logic [1:0]             fcr,
    input  logic [4:0]             mcr,
    input  logic [7:0]             lcr,
    input  logic [7:0]             msr,
    input  logic [7:0]             lsr,
    input  logic [FIFO_CNT_W-1:0]  rf_count,
    input  logic [FIFO_CNT_W-1:0]  tf_count,
    input  logic [2:0]             tstate,
    input  logic [3:0]             rstate,
    input  logic                   tx_done_i,
    input  logic                   rx_done_i,
    output logic                   trace_irq_o
);
    localparam int DEPTH = 1 << TRACE_AW;
    localparam int ENT_W = CNT_W + 8;

    localparam logic [UART_ADDR_W-1:0] A_CTRL  = UART_ADDR_W'(8'h00);
    localparam logic [UART_ADDR_W-1:0] A_POP   = UART_ADDR_W'(8'h04);
    localparam logic [UART_ADDR_W-1:0] A_LIVEA = UART_ADDR_W'(8'h08);
    localparam logic [UART_ADDR_W-1:0] A_LIVEB = UART_ADDR_W'(8'h0C);
    localparam logic [UART_ADDR_W-1:0] A_SNAPA = UART_ADDR_W'(8'h10);
    localparam logic [UART_ADDR_W-1:0] A_SNAPB = UART_ADDR_W'(8'h14);
    localparam logic [UART_ADDR_W-1:0] A_TXCNT = UART_ADDR_W'(8'h18);
    localparam logic [UART_ADDR_W-1:0] A_RXCNT = UART_ADDR_W'(8'h1C);

    logic [31:0]         word_a, word_b, status_word, rd_word;
    logic [31:0]         rd_data_reg, snap_a_reg, snap_b_reg;
    logic                ten_reg, frz_reg, ovf_reg, ovf_next, irq_reg;
    logic [CNT_W-1:0]    ts_reg;
    logic [7:0]          lsr_q_reg;
    logic [ENT_W-1:0]    trace_mem [DEPTH];
    logic [TRACE_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [TRACE_AW:0]   trace_cnt_reg, trace_cnt_next;
    logic [31:0]         cnt_word [2];
    logic [1:0]          done;
    logic                ctrl_wr, snap, clr, full, empty, pop, push_req, push;
    logic                unused_dat;

    assign unused_dat = ^wb_dat_i[31:4];

    assign word_a = {msr, lcr, iir, ier, lsr};
    assign word_b = 32'({fcr, mcr, rf_count, rstate, tf_count, tstate});

    assign ctrl_wr  = wb_we_i && (wb_adr_i == A_CTRL);
    assign snap     = ctrl_wr && wb_dat_i[0];
    assign clr      = ctrl_wr && wb_dat_i[1];

    assign full     = (trace_cnt_reg == (TRACE_AW+1)'(DEPTH));
    assign empty    = (trace_cnt_reg == '0);
    assign pop      = wb_re_i && (wb_adr_i == A_POP) && !empty;
    assign push_req = ten_reg && (lsr != lsr_q_reg);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req && (!full || pop);

    always_comb begin
        ovf_next = ovf_reg;
        if (push_req && full && !pop)
            ovf_next = 1'b1;
        else if (wb_re_i && (wb_adr_i == A_CTRL))
            ovf_next = 1'b0;
    end

    always_comb begin
        trace_cnt_next = trace_cnt_reg;
        case ({push, pop})
            2'b10:   trace_cnt_next = trace_cnt_reg + 1'b1;
            2'b01:   trace_cnt_next = trace_cnt_reg - 1'b1;
            default: trace_cnt_next = trace_cnt_reg;
        endcase
    end

    always_comb begin
        status_word = '0;
        status_word[24 +: TRACE_AW+1] = trace_cnt_reg;
        status_word[3] = ovf_reg;
        status_word[2] = frz_reg;
        status_word[1] = ten_reg;
    end

    always_comb begin
        rd_word = '0;
        case (wb_adr_i)
            A_CTRL:  rd_word = status_word;
            A_POP:   rd_word = empty ? 32'd0 : 32'(trace_mem[rd_ptr_reg]);
            A_LIVEA: rd_word = word_a;
            A_LIVEB: rd_word = word_b;
            A_SNAPA: rd_word = snap_a_reg;
            A_SNAPB: rd_word = snap_b_reg;
            A_TXCNT: rd_word = cnt_word[0];
            A_RXCNT: rd_word = cnt_word[1];
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push)
            trace_mem[wr_ptr_reg] <= {ts_reg, lsr};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_data_reg   <= '0;
            snap_a_reg    <= '0;
            snap_b_reg    <= '0;
            ten_reg       <= 1'b0;
            frz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            irq_reg       <= 1'b0;
            ts_reg        <= '0;
            lsr_q_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            trace_cnt_reg <= '0;
        end else begin
            if (wb_re_i)
                rd_data_reg <= rd_word;
            if (snap) begin
                snap_a_reg <= word_a;
                snap_b_reg <= word_b;
            end
            if (ctrl_wr) begin
                ten_reg <= wb_dat_i[2];
                frz_reg <= wb_dat_i[3];
            end
            ovf_reg       <= ovf_next;
            irq_reg       <= (trace_cnt_reg >= (TRACE_AW+1)'(IRQ_THRESH));
            ts_reg        <= ts_reg + 1'b1;
            lsr_q_reg     <= lsr;
            trace_cnt_reg <= trace_cnt_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Frame counters: clear beats freeze, freeze beats increment, saturate at all-ones.
    assign done = {rx_done_i, tx_done_i};
    for (genvar gi = 0; gi < 2; gi++) begin : g_frame_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i || clr)
                cnt_reg <= '0;
            else if (!frz_reg && done[gi] && (cnt_reg != '1))
                cnt_reg <= cnt_reg + 1'b1;
        end
        assign cnt_word[gi] = 32'(cnt_reg);
    end

    assign wb_dat32_o  = rd_data_reg;
    assign trace_irq_o = irq_reg;
endmodule
